// File: rtl/dma_arbiter_rr.sv
// dma_arbiter_rr: round-robin arbiter that hands a shared bus to one of
// NUM_CH DMA channels at a time. A grant lasts from the first edge that
// sees a request until the owner reports Done. Every grant is followed by
// at least one IDLE cycle. The owner channel's address, chip select and
// bus request are forwarded to the shared bus while the grant is held.
// The optional busy-cycle watchdog is built only when the macro
// DMA_ARB_TIMEOUT_EN is defined. When it is not defined, Timeout is tied
// low and a grant is held until Done or reset.
module dma_arbiter_rr #(
  parameter int NUM_CH         = 4,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                        Clk,
  input  logic                                        Rst,
  input  logic [NUM_CH-1:0]                           Req,
  input  logic [NUM_CH-1:0]                           Done,
  input  logic [NUM_CH*ADDR_W-1:0]                    Address_ch,
  input  logic [NUM_CH-1:0]                           Cs_ch,
  input  logic [NUM_CH-1:0]                           Bus_req_ch,
  output logic [NUM_CH-1:0]                           Grant,
  output logic [(($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1)-1:0] Grant_id,
  output logic                                        Dma_Idle,
  output logic [ADDR_W-1:0]                           Address,
  output logic                                        Cs,
  output logic                                        Bus_req,
  output logic                                        Timeout
);

  localparam int ID_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;

  // Elaboration guard: reject channel counts and watchdog limits outside the legal range.
  if ((NUM_CH < 2) || (NUM_CH > 16)) begin : g_bad_num_ch
    $error("dma_arbiter_rr: NUM_CH must be in 2..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("dma_arbiter_rr: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_owner;
  logic [ID_W-1:0] w_owner_nxt;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] w_rr_ptr_nxt;
  logic [ID_W-1:0] w_pick;
  logic [ID_W-1:0] w_owner_inc;
  logic            w_busy;
  logic            w_owner_done;
  logic            w_expire;

  // Return the first channel with a request, searching upward from ptr
  // and wrapping from NUM_CH-1 back to 0. When there is no request, ptr is returned.
  function automatic logic [ID_W-1:0] f_rr_pick(
    input logic [NUM_CH-1:0] req,
    input logic [ID_W-1:0]   ptr
  );
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!found && req[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end else begin
        pick  = pick;
        found = found;
      end
    end
    return pick;
  endfunction

  assign w_busy       = (r_state == ST_BUSY);
  assign w_owner_done = Done[r_owner];
  assign w_pick       = f_rr_pick(Req, r_rr_ptr);
  assign w_owner_inc  = (int'(r_owner) == (NUM_CH - 1)) ? '0 : (r_owner + 1'b1);

`ifdef DMA_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_busy_cnt;

  // Busy-cycle counter: zero in IDLE, so the first BUSY cycle reads 0, then +1 per BUSY cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_busy_cnt <= '0;
    end else if (!w_busy) begin
      r_busy_cnt <= '0;
    end else begin
      r_busy_cnt <= r_busy_cnt + 1'b1;
    end
  end

  // Expiry only counts when the owner has not also signalled Done this cycle.
  assign w_expire = w_busy && (r_busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !w_owner_done;
  assign Timeout  = w_expire;
`else
  assign w_expire = 1'b0;
  assign Timeout  = 1'b0;
`endif

  // State, owner and round-robin pointer registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Next-state logic: grant from IDLE on any request, and release from BUSY on owner Done or expiry.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (|Req) begin
          w_state_nxt = ST_BUSY;
          w_owner_nxt = w_pick;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_owner_done || w_expire) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = w_owner_inc;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_owner_nxt  = '0;
        w_rr_ptr_nxt = '0;
      end
    endcase
  end

  // Grant decode from the registered owner: at most one bit can be set.
  always_comb begin
    Grant = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      Grant[k] = w_busy && (r_owner == ID_W'(k));
    end
  end

  // Status decode: owner index while busy, and zero with Dma_Idle high otherwise.
  always_comb begin
    Grant_id = '0;
    Dma_Idle = 1'b1;
    if (w_busy) begin
      Grant_id = r_owner;
      Dma_Idle = 1'b0;
    end else begin
      Grant_id = '0;
      Dma_Idle = 1'b1;
    end
  end

  // Bus mux: forward the owner channel's signals while busy, and park the bus at zero when idle.
  always_comb begin
    Address = '0;
    Cs      = 1'b0;
    Bus_req = 1'b0;
    if (w_busy) begin
      Address = Address_ch[int'(r_owner)*ADDR_W +: ADDR_W];
      Cs      = Cs_ch[r_owner];
      Bus_req = Bus_req_ch[r_owner];
    end else begin
      Address = '0;
      Cs      = 1'b0;
      Bus_req = 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_arbiter_rr.sv
// Self-checking bench for dma_arbiter_rr (NUM_CH=4, ADDR_W=8, TIMEOUT_CYCLES=8).
// Directed scenarios plus a randomized run compared against a transaction-level model.
module tb_dma_arbiter_rr;

  localparam int NCH = 4;
  localparam int AW  = 8;
  localparam int TC  = 8;
`ifdef DMA_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          Clk;
  logic          Rst;
  logic [3:0]    Req;
  logic [3:0]    Done;
  logic [31:0]   Address_ch;
  logic [3:0]    Cs_ch;
  logic [3:0]    Bus_req_ch;
  logic [3:0]    Grant;
  logic [1:0]    Grant_id;
  logic          Dma_Idle;
  logic [7:0]    Address;
  logic          Cs;
  logic          Bus_req;
  logic          Timeout;

  int n_tests;
  int n_fail;

  // reference model: whether the bus is held, by whom, where the next search starts, how long held
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cnt;

  dma_arbiter_rr #(.NUM_CH(NCH), .ADDR_W(AW), .TIMEOUT_CYCLES(TC)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Done(Done), .Address_ch(Address_ch),
    .Cs_ch(Cs_ch), .Bus_req_ch(Bus_req_ch), .Grant(Grant), .Grant_id(Grant_id),
    .Dma_Idle(Dma_Idle), .Address(Address), .Cs(Cs), .Bus_req(Bus_req), .Timeout(Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // first requester at or after p, wrapping around
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NCH; k++) begin
      if (r[(p + k) % NCH]) return (p + k) % NCH;
    end
    return 0;
  endfunction

  function automatic logic [3:0] exp_grant();
    logic [3:0] one;
    one = 4'b0001;
    return m_busy ? (one << m_owner) : 4'b0000;
  endfunction

  function automatic logic [7:0] exp_addr();
    return m_busy ? Address_ch[m_owner*AW +: AW] : 8'h00;
  endfunction

  function automatic logic exp_timeout();
    return TO_EN && m_busy && (m_cnt == TC - 1) && !Done[m_owner];
  endfunction

  // advance the model by one clock edge, using the inputs the DUT samples at that edge
  task automatic model_edge();
    if (Rst) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (Req != 4'b0000) begin
        m_busy = 1'b1; m_owner = pick(Req, m_ptr); m_cnt = 0;
      end
    end else if (Done[m_owner] || (TO_EN && (m_cnt == TC - 1))) begin
      m_busy = 1'b0; m_ptr = (m_owner + 1) % NCH;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #2;
  endtask

  task automatic do_reset();
    Rst = 1'b1; Req = 4'b0000; Done = 4'b0000;
    tick(); tick();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Req = 4'b1111; Done = 4'b0000;
    tick(); tick();
    Rst = 1'b0; Req = 4'b0000;
    @(negedge Clk);
    n_tests++; if (Grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got %b want 0000", Grant); end
    n_tests++; if (Grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got %0d want 0", Grant_id); end
    n_tests++; if (Dma_Idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", Dma_Idle); end
    n_tests++; if (Address !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h want 00", Address); end
    n_tests++; if ({Cs, Bus_req, Timeout} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl got %b want 000", {Cs, Bus_req, Timeout}); end
  endtask

  task automatic test_reset_busy();
    do_reset();
    Req = 4'b0100; Address_ch = 32'hA5C3_7E19;
    tick();
    @(negedge Clk);
    n_tests++; if (Grant !== 4'b0100) begin n_fail++; $display("FAIL rstbusy_pre got %b want 0100", Grant); end
    Rst = 1'b1;
    tick(); tick();
    Rst = 1'b0; Req = 4'b0000;
    @(negedge Clk);
    n_tests++; if (Grant !== 4'b0000) begin n_fail++; $display("FAIL rstbusy_grant got %b want 0000", Grant); end
    n_tests++; if (Dma_Idle !== 1'b1) begin n_fail++; $display("FAIL rstbusy_idle got %b want 1", Dma_Idle); end
    n_tests++; if (Address !== 8'h00) begin n_fail++; $display("FAIL rstbusy_addr got %h want 00", Address); end
  endtask

  task automatic test_priority();
    logic [31:0] av;
    do_reset();
    av = $urandom; Address_ch = av; Cs_ch = 4'b0010; Bus_req_ch = 4'b1101;
    Req = 4'b0110;
    tick();
    @(negedge Clk);
    n_tests++; if (Grant !== 4'b0010) begin n_fail++; $display("FAIL prio_grant got %b want 0010", Grant); end
    n_tests++; if (Grant_id !== 2'd1) begin n_fail++; $display("FAIL prio_id got %0d want 1", Grant_id); end
    n_tests++; if (Address !== av[15:8]) begin n_fail++; $display("FAIL prio_addr got %h want %h", Address, av[15:8]); end
    n_tests++; if ({Cs, Bus_req} !== 2'b10) begin n_fail++; $display("FAIL prio_mux got %b want 10", {Cs, Bus_req}); end
    Done = 4'b0010;
    tick();
    Done = 4'b0000;
    @(negedge Clk);
    n_tests++; if ({Grant, Dma_Idle} !== 5'b00001) begin n_fail++; $display("FAIL prio_gap got %b want 00001", {Grant, Dma_Idle}); end
    tick();
    @(negedge Clk);
    n_tests++; if (Grant !== 4'b0100) begin n_fail++; $display("FAIL prio_next got %b want 0100", Grant); end
    n_tests++; if ({Cs, Bus_req} !== 2'b01) begin n_fail++; $display("FAIL prio_next_mux got %b want 01", {Cs, Bus_req}); end
    Done = 4'b0100; Req = 4'b0000;
    tick();
    Done = 4'b0000;
  endtask

  task automatic test_rotation();
    logic [3:0] want;
    do_reset();
    Req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      want = 4'b0001 << (i % NCH);
      tick();
      @(negedge Clk);
      n_tests++; if (Grant !== want) begin n_fail++; $display("FAIL rot_grant%0d got %b want %b", i, Grant, want); end
      Done = want;
      tick();
      Done = 4'b0000;
      @(negedge Clk);
      n_tests++; if (Dma_Idle !== 1'b1 || Grant !== 4'b0000) begin n_fail++; $display("FAIL rot_gap%0d got idle=%b grant=%b want idle=1 grant=0000", i, Dma_Idle, Grant); end
    end
    Req = 4'b0000;
    tick();
  endtask

  task automatic test_non_owner_done();
    do_reset();
    Req = 4'b0100;
    tick();
    Done = 4'b1011;
    tick();
    @(negedge Clk);
    n_tests++; if (Grant !== 4'b0100) begin n_fail++; $display("FAIL nonowner_done got %b want 0100", Grant); end
    Done = 4'b0000; Req = 4'b0000;
    tick(); tick(); tick();
    @(negedge Clk);
    n_tests++; if (Grant !== 4'b0100 || Grant_id !== 2'd2) begin n_fail++; $display("FAIL reqdrop_hold got %b/%0d want 0100/2", Grant, Grant_id); end
    Done = 4'b0100;
    tick();
    Done = 4'b0000;
    @(negedge Clk);
    n_tests++; if (Dma_Idle !== 1'b1) begin n_fail++; $display("FAIL owner_release got idle=%b want 1", Dma_Idle); end
    Done = 4'b1111;
    tick();
    Done = 4'b0000;
    @(negedge Clk);
    n_tests++; if (Dma_Idle !== 1'b1) begin n_fail++; $display("FAIL idle_done_ignored got idle=%b want 1", Dma_Idle); end
  endtask

  task automatic test_single_cycle();
    do_reset();
    Req = 4'b0001; Done = 4'b0001;
    tick();
    @(negedge Clk);
    n_tests++; if (Grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant got %b want 0001", Grant); end
    tick();
    @(negedge Clk);
    n_tests++; if (Dma_Idle !== 1'b1) begin n_fail++; $display("FAIL single_release got idle=%b want 1", Dma_Idle); end
    tick();
    @(negedge Clk);
    n_tests++; if (Grant !== 4'b0001) begin n_fail++; $display("FAIL single_regrant got %b want 0001", Grant); end
    tick();
    Req = 4'b0011;
    tick();
    @(negedge Clk);
    n_tests++; if (Grant !== 4'b0010) begin n_fail++; $display("FAIL single_other got %b want 0010", Grant); end
    Done = 4'b0010; Req = 4'b0000;
    tick();
    Done = 4'b0000;
  endtask

  task automatic test_timeout();
    int pulses;
    int bad;
    do_reset();
    Req = 4'b1000;
    tick();
    Req = 4'b1001;
    pulses = 0; bad = 0;
`ifdef DMA_ARB_TIMEOUT_EN
    for (int c = 1; c <= TC; c++) begin
      @(negedge Clk);
      if (Timeout !== ((c == TC) ? 1'b1 : 1'b0)) bad++;
      if (Grant !== 4'b1000) bad++;
      tick();
    end
    @(negedge Clk);
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL timeout_pulse got %0d bad cycles want 0", bad); end
    n_tests++; if (Dma_Idle !== 1'b1 || Timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_release got idle=%b to=%b want 1/0", Dma_Idle, Timeout); end
    tick();
    @(negedge Clk);
    n_tests++; if (Grant !== 4'b0001) begin n_fail++; $display("FAIL timeout_next got %b want 0001", Grant); end
`else
    for (int c = 1; c <= 300; c++) begin
      @(negedge Clk);
      if (Timeout !== 1'b0) pulses++;
      if (Grant !== 4'b1000) bad++;
      tick();
    end
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL hold_timeout got %0d pulses want 0", pulses); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL hold_grant got %0d bad cycles want 0", bad); end
`endif
    Req = 4'b0000; Done = 4'b1111;
    tick();
    Done = 4'b0000;
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 600; i++) begin
      Rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) < 7) Req = 4'($urandom);
      sel = $urandom_range(0, 3);
      if (sel == 0) Done = 4'b0001 << m_owner;
      else if (sel == 1) Done = 4'($urandom);
      else Done = 4'b0000;
      Address_ch = $urandom; Cs_ch = 4'($urandom); Bus_req_ch = 4'($urandom);
      @(negedge Clk);
      n_tests++;
      if (Grant !== exp_grant() || Grant_id !== (m_busy ? 2'(m_owner) : 2'd0) || Dma_Idle !== !m_busy) begin
        n_fail++; $display("FAIL rnd_grant cyc %0d got %b/%0d/%b want %b/%0d/%b", i, Grant, Grant_id, Dma_Idle, exp_grant(), m_busy ? m_owner : 0, !m_busy);
      end
      n_tests++;
      if (Address !== exp_addr() || Cs !== (m_busy && Cs_ch[m_owner]) || Bus_req !== (m_busy && Bus_req_ch[m_owner])) begin
        n_fail++; $display("FAIL rnd_mux cyc %0d got %h/%b/%b want %h/%b/%b", i, Address, Cs, Bus_req, exp_addr(), m_busy && Cs_ch[m_owner], m_busy && Bus_req_ch[m_owner]);
      end
      n_tests++;
      if (Timeout !== exp_timeout() || $countones(Grant) > 1) begin
        n_fail++; $display("FAIL rnd_timeout cyc %0d got to=%b grant=%b want to=%b onehot", i, Timeout, Grant, exp_timeout());
      end
      tick();
    end
    Rst = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    Rst = 1'b1; Req = 4'b0000; Done = 4'b0000;
    Address_ch = 32'h0; Cs_ch = 4'b0000; Bus_req_ch = 4'b0000;
    test_reset();
    test_reset_busy();
    test_priority();
    test_rotation();
    test_non_owner_done();
    test_single_cycle();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global guard so the run can never hang
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dma_arbiter_rr.md
DMA_ARBITER_RR -- requirements
Module: dma_arbiter_rr

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of DMA channels, legal range 2..16.
REQ-002 The block SHALL have parameter ADDR_W, default 8: bus address width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 256: busy-cycle limit, used only when DMA_ARB_TIMEOUT_EN is defined.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous active-high reset.
- Req  input  NUM_CH  per-channel transfer request, level.
- Done  input  NUM_CH  per-channel end-of-transfer pulse.
- Address_ch  input  NUM_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- Cs_ch  input  NUM_CH  per-channel chip select.
- Bus_req_ch  input  NUM_CH  per-channel bus request.
- Grant  output  NUM_CH  one-hot grant, or all zero.
- Grant_id  output  max(1,$clog2(NUM_CH))  index of the granted channel; 0 when idle.
- Dma_Idle  output  1  high when no channel is granted.
- Address  output  ADDR_W  muxed address.
- Cs  output  1  muxed chip select.
- Bus_req  output  1  muxed bus request.
- Timeout  output  1  one-cycle pulse on forced release.

Function
REQ-006 The FSM SHALL have two states, IDLE and BUSY, held in a registered state plus a registered owner index.
REQ-007 In IDLE with Req nonzero, on the next edge the FSM SHALL enter BUSY and set owner to the first channel with Req high, searching upward from rr_ptr and wrapping from NUM_CH-1 to 0.
REQ-008 Grant, Grant_id and Dma_Idle SHALL be decoded combinationally from the registered state and owner, giving one-cycle latency from Req to Grant.
REQ-009 In BUSY, Done[owner] high SHALL return the FSM to IDLE on the next edge and load rr_ptr with (owner+1) mod NUM_CH.
REQ-010 Done on any non-owner channel SHALL be ignored.
REQ-011 Deassertion of Req[owner] during BUSY SHALL NOT release the grant; only Done, timeout or reset releases it.
REQ-012 IDLE SHALL last at least one cycle between grants, so back-to-back transfers have a one-cycle gap with Dma_Idle=1.
REQ-013 In BUSY, Address, Cs and Bus_req SHALL combinationally follow Address_ch, Cs_ch and Bus_req_ch of the owner channel.
REQ-014 In IDLE, Address SHALL be '0, Cs SHALL be 0 and Bus_req SHALL be 0.
REQ-015 Done[owner] arriving in the first BUSY cycle SHALL be honoured, giving a single-cycle grant.
REQ-016 Done inputs SHALL be ignored while in IDLE.
REQ-017 Grant SHALL never have more than one bit set in any cycle.

Reset
REQ-018 Rst high at a rising Clk edge SHALL force state=IDLE, owner=0, rr_ptr=0 and clear the timeout counter, overriding all other inputs including a transfer in progress.
REQ-019 In the cycle after reset, outputs SHALL be Grant=0, Grant_id=0, Dma_Idle=1, Address=0, Cs=0, Bus_req=0 and Timeout=0.

Configuration
REQ-020 With macro DMA_ARB_TIMEOUT_EN defined, a busy counter SHALL clear on entry to BUSY and increment on each BUSY cycle.
REQ-021 With DMA_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 without Done[owner], the FSM SHALL go to IDLE on the next edge, update rr_ptr as in REQ-009 and pulse Timeout for exactly that one cycle.
REQ-022 With DMA_ARB_TIMEOUT_EN defined, Done[owner] in the same cycle as expiry SHALL take precedence, with no Timeout pulse.
REQ-023 Without DMA_ARB_TIMEOUT_EN, no counter SHALL be implemented, Timeout SHALL be tied to 0 and grants SHALL be held indefinitely.

Verification (NUM_CH=4, ADDR_W=8)
REQ-024 The bench SHALL cover: Rst=1 for 2 cycles during BUSY -> next cycle Grant=0, Dma_Idle=1, Address=0x00.
REQ-025 The bench SHALL cover: Req=4'b0110 from reset -> Grant=4'b0010, Grant_id=1, Address=Address_ch[15:8]; Done[1] -> one idle cycle -> Grant=4'b0100.
REQ-026 The bench SHALL cover: Req=4'b1111 held, Done pulsed each grant -> grant order 0,1,2,3,0 with one Dma_Idle cycle between grants.
REQ-027 The bench SHALL cover: owner=2, Done=4'b1011 -> grant held; Req[2] dropped -> grant held; Done[2] -> release.
REQ-028 The bench SHALL cover: DMA_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, owner 3, no Done -> Timeout pulses on BUSY cycle 8, next grant goes to channel 0 if requesting.
REQ-029 The bench SHALL cover: Req[0]=1 with Done[0]=1 held -> grant of exactly one cycle, then IDLE, then regrant to channel 0 only if it is the sole requester.
